dmem_arbiter: RTL

- Two-port arbiter and sequencer in front of the single-port data memory (256 x 32-bit words, combinational read, synchronous word write).
- Shares the memory between the core load/store unit (m0) and a DMA/debug master (m1) using round-robin arbitration.
- Adds byte-enable stores by sequencing a read-modify-write, since the memory only writes full words.
- Returns one response per accepted request, and flags out-of-range addresses.

---
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer in front of a single-port data memory.
// Byte-enable stores become a read-modify-write, and out-of-range addresses get an error response.
module dmem_arbiter #(
    parameter int ADDR_LSB   = 2,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_resp_valid,
    output logic [31:0] m0_resp_rdata,
    output logic        m0_resp_err,

    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_resp_valid,
    output logic [31:0] m1_resp_rdata,
    output logic        m1_resp_err,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_waddr_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] mem_raddr_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    state_t      r_state, w_next;
    logic        r_ptr;          // 0: m0 wins a tie, 1: m1 wins a tie
    logic        r_gnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_old_word;
    logic        r_err;

    logic        w_pick;
    logic        w_accept;
    logic        w_range_err;
    logic        w_mem_req;
    logic [31:0] w_mem_wdata;
    logic [31:0] w_merged;
    logic [31:0] w_word_addr;
    logic [31:0] w_rdata;
    logic        w_resp;
    logic        w_unused_addr;

    assign w_pick      = (m0_req_valid && m1_req_valid) ? r_ptr : m1_req_valid;
    assign w_range_err = |r_addr[31:ADDR_LSB+DEPTH_LOG2];
    assign w_word_addr = {r_addr[31:ADDR_LSB], {ADDR_LSB{1'b0}}};
    assign w_unused_addr = &{1'b0, r_addr[ADDR_LSB-1:0]};

    always_comb begin
        // NOTE: every combinational output is given a default first, so no path can infer a latch.
        w_merged = '0;
        for (int k = 0; k < 4; k++) begin
            w_merged[8*k +: 8] = r_be[k] ? r_wdata[8*k +: 8] : r_old_word[8*k +: 8];
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_wdata = '0;
        case (r_state)
            IDLE: begin
                if (m0_req_valid || m1_req_valid) begin
                    w_accept = 1'b1;
                    w_next   = ACCESS;
                end
            end
            ACCESS: begin
                w_next = RESP;
                // Errors, loads and empty-mask stores never touch the memory.
                if (!w_range_err && r_we && (r_be != 4'h0)) begin
                    if (r_be == 4'hF) begin
                        w_mem_req   = 1'b1;
                        w_mem_wdata = r_wdata;
                    end else begin
                        w_next = MERGE;
                    end
                end
            end
            MERGE: begin
                w_mem_req   = 1'b1;
                w_mem_wdata = w_merged;
                w_next      = RESP;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Reset overrides everything combinationally: no grant, no write, no response.
    assign m0_req_ready = w_accept && !rst && !w_pick;
    assign m1_req_ready = w_accept && !rst &&  w_pick;

    assign mem_req_o   = w_mem_req && !rst;
    assign mem_we_o    = mem_req_o;
    assign mem_wdata_o = mem_req_o ? w_mem_wdata : '0;
    assign mem_waddr_o = w_word_addr;
    assign mem_raddr_o = w_word_addr;

    assign w_resp  = (r_state == RESP) && !rst;
    assign w_rdata = (!r_we && !r_err) ? r_old_word : '0;

    assign m0_resp_valid = w_resp && !r_gnt;
    assign m0_resp_rdata = m0_resp_valid ? w_rdata : '0;
    assign m0_resp_err   = m0_resp_valid && r_err;
    assign m1_resp_valid = w_resp && r_gnt;
    assign m1_resp_rdata = m1_resp_valid ? w_rdata : '0;
    assign m1_resp_err   = m1_resp_valid && r_err;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= 1'b0;
            r_gnt      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_old_word <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_gnt   <= w_pick;
                r_ptr   <= ~w_pick;
                r_we    <= w_pick ? m1_we    : m0_we;
                r_addr  <= w_pick ? m1_addr  : m0_addr;
                r_wdata <= w_pick ? m1_wdata : m0_wdata;
                r_be    <= w_pick ? m1_be    : m0_be;
            end
            if (r_state == ACCESS) begin
                r_old_word <= mem_rdata_i;
                r_err      <= w_range_err;
            end
        end
    end

endmodule
